gray_step_decoder: RTL and testbench

GRAY_STEP_DECODER -- requirements
Module: gray_step_decoder

---
 rtl/gray_step_decoder.sv | 236 +++++++++++++++++++++++
 tb/tb_gray_step_decoder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_step_decoder.sv
// -----------------------------------------------------------------------------
// gray_step_decoder
//
// Purpose:
//   Decodes an asynchronous Gray-coded bus, such as an absolute encoder or a
//   looped-back LED bus, into binary. The decoder does four things:
//     - It resynchronises the bus and debounces it with a stability filter.
//     - It classifies every newly accepted value as +1, -1 or an illegal skip
//       relative to the previously accepted value.
//     - It keeps a signed position accumulator.
//     - It keeps a saturating count of skip errors.
//
// Ports:
//   clk        in   1      sole clock, rising edge
//   resetn     in   1      asynchronous active-low reset
//   gray_in    in   BITS   asynchronous Gray-coded input
//   clr        in   1      synchronous clear of position and err_count
//   bin_out    out  BITS   binary value of the last accepted input
//   valid      out  1      one-cycle pulse per accepted new value
//   step_up    out  1      one-cycle pulse: accepted = previous + 1 (mod 2^BITS)
//   step_dn    out  1      one-cycle pulse: accepted = previous - 1 (mod 2^BITS)
//   skip_err   out  1      one-cycle pulse: accepted is neither +1 nor -1
//   position   out  POS_W  two's complement step accumulator, wraps
//   err_count  out  8      saturating count of skip_err events
//
// Timing:
//   A value that settles on gray_in just before clock edge 1 goes through
//   these stages:
//     - It leaves the synchroniser on edge 2.
//     - It is loaded as the filter candidate on edge 3.
//     - Its stability counter reaches 2^FILT_LOG2-1 on edge 2^FILT_LOG2+2.
//     - It is accepted, with valid pulsing, on edge 2^FILT_LOG2+3.
//   The timing is the same straight out of reset. A fill flag tracks the
//   synchroniser pipeline, and the candidate starts out empty, so the reset
//   value of the synchroniser is never mistaken for an observed input.
// -----------------------------------------------------------------------------
module gray_step_decoder #(
  parameter int BITS      = 5,
  parameter int FILT_LOG2 = 4,
  parameter int POS_W     = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [BITS-1:0]  gray_in,
  input  logic             clr,
  output logic [BITS-1:0]  bin_out,
  output logic             valid,
  output logic             step_up,
  output logic             step_dn,
  output logic             skip_err,
  output logic [POS_W-1:0] position,
  output logic [7:0]       err_count
);

  localparam logic [FILT_LOG2-1:0] CNT_MAX  = '1;
  localparam logic [BITS-1:0]      DELTA_UP = BITS'(1);
  localparam logic [BITS-1:0]      DELTA_DN = '1;
  localparam logic [7:0]           ERR_MAX  = 8'hFF;

  typedef enum logic {
    UNPRIMED = 1'b0,  // no value accepted since reset
    TRACK    = 1'b1   // a reference value exists, classify every change
  } state_t;

  // ---------------------------------------------------------------------------
  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  // ---------------------------------------------------------------------------
  function automatic logic [BITS-1:0] gray2bin(input logic [BITS-1:0] g);
    logic [BITS-1:0] b;
    b[BITS-1] = g[BITS-1];
    for (int i = BITS - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser, with a fill flag that marks when sync2_q holds a
  // real sample rather than its reset value.
  // ---------------------------------------------------------------------------
  logic [BITS-1:0] sync1_q;
  logic [BITS-1:0] sync2_q;
  logic [1:0]      fill_q;
  logic            synced_ok;

  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples the pre-edge value of its neighbours, exactly like hardware.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
      fill_q  <= '0;
    end else begin
      sync1_q <= gray_in;
      sync2_q <= sync1_q;
      fill_q  <= {fill_q[0], 1'b1};
    end
  end

  assign synced_ok = fill_q[1];

  // ---------------------------------------------------------------------------
  // Stability filter. A changed sample reloads the candidate and restarts the
  // count. A matching sample counts up and saturates. The candidate is empty
  // after reset, so the first real sample always counts as a change.
  // ---------------------------------------------------------------------------
  logic [BITS-1:0]      cand_q;
  logic                 cand_vld_q;
  logic [FILT_LOG2-1:0] cnt_q;
  logic                 sample_differs;

  assign sample_differs = !cand_vld_q || (sync2_q != cand_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cand_q     <= '0;
      cand_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else if (synced_ok) begin
      if (sample_differs) begin
        cand_q     <= sync2_q;
        cand_vld_q <= 1'b1;
        cnt_q      <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + FILT_LOG2'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Acceptance. Once a value is accepted, acc_gray_q equals the candidate, so
  // a saturated counter cannot fire a second time for the same value. A
  // return to the accepted value is likewise silent. In UNPRIMED any stable
  // value is accepted, including one equal to the reset value of acc_gray_q.
  // ---------------------------------------------------------------------------
  state_t          state_q;
  state_t          state_d;
  logic [BITS-1:0] acc_gray_q;
  logic            accept;
  logic [BITS-1:0] cand_bin;
  logic [BITS-1:0] delta;

  assign accept = synced_ok && !sample_differs && (cnt_q == CNT_MAX) &&
                  ((state_q == UNPRIMED) || (cand_q != acc_gray_q));

  assign cand_bin = gray2bin(cand_q);
  assign delta    = cand_bin - bin_out;  // modulo 2^BITS, so wrap is handled

  // ---------------------------------------------------------------------------
  // FSM: state register, plus a next-state and event classification process.
  // ---------------------------------------------------------------------------
  logic ev_up;
  logic ev_dn;
  logic ev_err;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= UNPRIMED;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this combinational block gets a default first, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ev_up   = 1'b0;
    ev_dn   = 1'b0;
    ev_err  = 1'b0;
    unique case (state_q)
      UNPRIMED: begin
        if (accept) begin
          state_d = TRACK;
        end
      end
      TRACK: begin
        if (accept) begin
          if (delta == DELTA_UP) begin
            ev_up = 1'b1;
          end else if (delta == DELTA_DN) begin
            ev_dn = 1'b1;
          end else begin
            ev_err = 1'b1;
          end
        end
      end
      default: state_d = UNPRIMED;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs. The pulses and bin_out update on the same edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_gray_q <= '0;
      bin_out    <= '0;
      valid      <= 1'b0;
      step_up    <= 1'b0;
      step_dn    <= 1'b0;
      skip_err   <= 1'b0;
    end else begin
      valid    <= accept;
      step_up  <= ev_up;
      step_dn  <= ev_dn;
      skip_err <= ev_err;
      if (accept) begin
        acc_gray_q <= cand_q;
        bin_out    <= cand_bin;
      end
    end
  end

  // clr takes priority over a coincident step or error. The pulses above
  // still fire, because clr only touches the accumulators.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      position  <= '0;
      err_count <= '0;
    end else if (clr) begin
      position  <= '0;
      err_count <= '0;
    end else begin
      if (ev_up) begin
        position <= position + POS_W'(1);
      end else if (ev_dn) begin
        position <= position - POS_W'(1);
      end
      if (ev_err && (err_count != ERR_MAX)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_gray_step_decoder.sv
// -----------------------------------------------------------------------------
// tb_gray_step_decoder
//
// Testbench for gray_step_decoder. The reference model records every gray_in
// sample taken since reset. It accepts a value on edge E when these three
// conditions hold:
//   - The 2^FILT_LOG2+1 samples ending two edges before E are identical.
//     Two edges is the synchroniser depth.
//   - At least that many samples exist since reset.
//   - The value is new, or nothing has been accepted yet.
// Classification uses plain modular arithmetic on binary values.
// -----------------------------------------------------------------------------
module tb_gray_step_decoder;

  localparam int BITS      = 5;
  localparam int FILT_LOG2 = 4;
  localparam int POS_W     = 16;
  localparam int MASK      = (1 << BITS) - 1;
  localparam int POS_MASK  = (1 << POS_W) - 1;
  localparam int NEED      = (1 << FILT_LOG2) + 1;  // identical samples needed
  localparam int LAG       = 2;                     // synchroniser depth

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [BITS-1:0]  gray_in = '0;
  logic             clr = 1'b0;
  logic [BITS-1:0]  bin_out;
  logic             valid;
  logic             step_up;
  logic             step_dn;
  logic             skip_err;
  logic [POS_W-1:0] position;
  logic [7:0]       err_count;

  gray_step_decoder #(.BITS(BITS), .FILT_LOG2(FILT_LOG2), .POS_W(POS_W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .gray_in   (gray_in),
    .clr       (clr),
    .bin_out   (bin_out),
    .valid     (valid),
    .step_up   (step_up),
    .step_dn   (step_dn),
    .skip_err  (skip_err),
    .position  (position),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int hist[$];          // gray_in samples since reset, index 0 = edge 1
  int edge_no;
  bit primed;
  int acc_val;          // last accepted binary value
  bit m_valid, m_up, m_dn, m_skip;
  int m_pos, m_err;

  // Activity seen on the DUT outputs, used by the scenario-level checks.
  int cnt_valid, cnt_up, cnt_dn, cnt_skip;
  int first_valid_edge;

  function automatic logic [BITS-1:0] to_gray(input int b);
    return BITS'(b ^ (b >> 1));
  endfunction

  function automatic int from_gray(input int g);
    int b = 0;
    for (int k = 0; k < BITS; k++) b = b ^ (g >> k);
    return b & MASK;
  endfunction

  function automatic bit accept_at(input int e, output int v);
    int first;
    v = 0;
    if (e < NEED + LAG) return 1'b0;
    first = e - LAG - NEED;
    for (int k = first + 1; k <= e - LAG - 1; k++)
      if (hist[k] != hist[first]) return 1'b0;
    v = from_gray(hist[first]);
    return (!primed || v != acc_val);
  endfunction

  task automatic model_step(input bit c);
    int v;
    int d;
    m_valid = accept_at(edge_no, v);
    m_up = 1'b0; m_dn = 1'b0; m_skip = 1'b0;
    if (m_valid) begin
      if (primed) begin
        d = (v - acc_val) & MASK;
        if (d == 1)         m_up = 1'b1;
        else if (d == MASK) m_dn = 1'b1;
        else                m_skip = 1'b1;
      end
      acc_val = v;
      primed  = 1'b1;
    end
    if (c) begin
      m_pos = 0;
      m_err = 0;
    end else begin
      m_pos = (m_pos + (m_up ? 1 : 0) - (m_dn ? 1 : 0)) & POS_MASK;
      if (m_skip && m_err < 255) m_err++;
    end
  endtask

  task automatic model_clear();
    hist.delete();
    edge_no = 0; primed = 1'b0; acc_val = 0;
    m_valid = 1'b0; m_up = 1'b0; m_dn = 1'b0; m_skip = 1'b0;
    m_pos = 0; m_err = 0;
    first_valid_edge = -1;
  endtask

  task automatic clear_counts();
    cnt_valid = 0; cnt_up = 0; cnt_dn = 0; cnt_skip = 0;
  endtask

  // One clock: sample on the rising edge, compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    hist.push_back(int'(gray_in));
    edge_no++;
    model_step(clr);
    @(negedge clk);
    check("valid",     valid,     m_valid);
    check("step_up",   step_up,   m_up);
    check("step_dn",   step_dn,   m_dn);
    check("skip_err",  skip_err,  m_skip);
    check("bin_out",   bin_out,   acc_val);
    check("position",  position,  m_pos);
    check("err_count", err_count, m_err);
    if (valid)    cnt_valid++;
    if (step_up)  cnt_up++;
    if (step_dn)  cnt_dn++;
    if (skip_err) cnt_skip++;
    if (valid && first_valid_edge < 0) first_valid_edge = edge_no;
  endtask

  task automatic hold_bin(input int b, input int n);
    gray_in = to_gray(b & MASK);
    repeat (n) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {valid, step_up, step_dn, skip_err}, 4'b0000);
    check({tag, "_bin"},   bin_out,   0);
    check({tag, "_pos"},   position,  0);
    check({tag, "_err"},   err_count, 0);
  endtask

  // Called on a falling edge. Asserts reset, checks that the clear is
  // immediate, and releases on a later falling edge.
  task automatic do_reset();
    resetn = 1'b0;
    #1;
    check_all_zero("reset_async");
    model_clear();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : main
    int  pos_before;
    int  tgt;
    int  len;
    bit  hit;
    int  v;

    model_clear();
    clear_counts();

    // Power-up reset.
    #2;
    check_all_zero("reset_init");
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Prime on 0: valid on edge 19, no step or error.
    hold_bin(0, 25);
    check("prime_edge", first_valid_edge, 19);
    check("prime_steps", cnt_up + cnt_dn + cnt_skip, 0);

    // Full revolution upwards, including the 31 -> 0 wrap.
    clear_counts();
    for (int b = 1; b <= 32; b++) hold_bin(b % 32, 40);
    check("rev_up_pulses", cnt_up, 32);
    check("rev_up_pos", position, 32);
    check("rev_up_err", err_count, 0);
    check("rev_up_bin", bin_out, 0);

    // clr lands on the same edge as a step_up: clr wins, the pulse stays.
    gray_in = to_gray(1);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (accept_at(edge_no + 1, v)) begin
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_step_up", step_up, 1);
        check("clr_step_pos", position, 0);
        hit = 1'b1;
      end else begin
        tick();
      end
    end
    check("clr_step_reached", hit, 1);
    hold_bin(1, 10);

    // Move to 3, clear, then step 2,1,0,31 downwards.
    hold_bin(2, 25);
    hold_bin(3, 25);
    clr = 1'b1; tick(); clr = 1'b0;
    clear_counts();
    hold_bin(2, 25); hold_bin(1, 25); hold_bin(0, 25); hold_bin(31, 25);
    check("dn_pulses", cnt_dn, 4);
    check("dn_pos", position, 16'hFFFC);

    // Walk up to 5, then jump to 9.
    for (int b = 0; b <= 5; b++) hold_bin(b, 25);
    pos_before = int'(position);
    clear_counts();
    hold_bin(9, 25);
    check("jump_skip", cnt_skip, 1);
    check("jump_err", err_count, 1);
    check("jump_pos", position, pos_before);
    check("jump_bin", bin_out, 9);

    // 259 more jumps: the error count saturates at 255.
    for (int i = 0; i < 259; i++) hold_bin((i % 2 == 0) ? 5 : 9, 20);
    check("err_saturate", err_count, 255);
    check("err_sat_pos", position, pos_before);

    // A 10-cycle single-bit glitch is ignored.
    clear_counts();
    gray_in = to_gray(5) ^ BITS'(4);
    repeat (10) tick();
    hold_bin(5, 30);
    check("glitch_valid", cnt_valid, 0);
    check("glitch_bin", bin_out, 5);

    // A hold of the minimum stable length is accepted.
    gray_in = to_gray(5) ^ BITS'(4);
    repeat (NEED) tick();
    hold_bin(5, 30);
    check("hold_accept", cnt_valid, 2);

    // Reset mid-filter, then re-prime without a step.
    gray_in = to_gray(12);
    repeat (8) tick();
    do_reset();
    clear_counts();
    hold_bin(12, 25);
    check("reprime_edge", first_valid_edge, 19);
    check("reprime_bin", bin_out, 12);
    check("reprime_steps", cnt_up + cnt_dn + cnt_skip, 0);

    // Randomised segments, biased towards legal steps, with occasional clr
    // and one reset.
    for (int s = 0; s < 300; s++) begin
      case ($urandom_range(0, 3))
        0, 1:    tgt = (acc_val + 1) & MASK;
        2:       tgt = (acc_val + MASK) & MASK;
        default: tgt = int'($urandom_range(0, MASK));
      endcase
      len = int'($urandom_range(1, 30));
      gray_in = to_gray(tgt);
      for (int i = 0; i < len; i++) begin
        clr = ($urandom_range(0, 24) == 0);
        tick();
      end
      clr = 1'b0;
      if (s == 150) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
